my_and: RTL and testbench
=========================

MY_AND -- requirements
Module: my_and

Interface
REQ-001 Parameter CNT_W, default 16: width of the rising-edge counter rise_cnt, legal range 2..32.
REQ-002 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port a, input, 1 bit: first truth-table operand.
REQ-005 Port b, input, 1 bit: second truth-table operand.
REQ-006 Port out, output, 1 bit: combinational truth-table result.
REQ-007 Port out_q, output, 1 bit: registered truth-table result.
REQ-008 Port out_vld, output, 1 bit: out_q holds a result sampled since reset.
REQ-009 Port x_flag, output, 1 bit: sticky flag; an unknown operand was sampled.
REQ-010 Port rise_cnt, output, CNT_W bits: count of out_q 0->1 transitions.

Function
REQ-011 out SHALL follow an exact four-row table with no clocking and no reset dependence: a=0,b=0 -> 0; a=0,b=1 -> 0; a=1,b=0 -> 0; a=1,b=1 -> 1.
REQ-012 out SHALL be x for any input combination not in the table.
REQ-013 The x result of REQ-012 SHALL include rows where either operand is x or z, even when the other operand is 0 (e.g. a=0, b=x -> x).
REQ-014 A combination SHALL be "known" when a and b are both 0 or 1.
REQ-015 On a rising clk edge with rst=0 and a known combination, out_q SHALL load the table result, giving one-cycle latency from operands to out_q.
REQ-016 On a rising clk edge with rst=0 and an unknown combination, out_q SHALL hold its previous value, and x_flag SHALL set to 1.
REQ-017 x_flag SHALL be sticky until reset.
REQ-018 out_vld SHALL become 1 on the first rising edge with rst=0 and a known combination.
REQ-019 Once set, out_vld SHALL remain 1 until reset.
REQ-020 rise_cnt SHALL increment by 1 on each edge where out_q is currently 0 and loads 1.
REQ-021 rise_cnt SHALL saturate at all-ones (2^CNT_W-1) and not wrap.
REQ-022 Repeated cycles with a=b=1 SHALL NOT increment rise_cnt more than once; only transitions count.
REQ-023 The 0->1 count of REQ-020 SHALL include the first load of 1 after reset, because out_q resets to 0.
REQ-024 Operand changes between clock edges SHALL affect only out, never the registered outputs.

Reset
REQ-025 rst SHALL be sampled only on the rising edge of clk.
REQ-026 With rst=1 at a rising edge, out_q=0, out_vld=0, x_flag=0 and rise_cnt=0 SHALL take effect regardless of a and b.
REQ-027 rst SHALL take priority over every other update in the same cycle, including a pending 0->1 count and an x_flag set.
REQ-028 out SHALL remain purely combinational during reset.
REQ-029 Reset asserted mid-operation SHALL discard all accumulated state.
REQ-030 The first post-reset edge SHALL behave exactly as after power-up reset.

Verification
REQ-031 Scenario, truth table: with rst=0, a=0,b=0 -> out=0; then a=1 -> out=0; then b=1 -> out=1, and after the next edge out_q=1, out_vld=1 and rise_cnt=1.
REQ-032 Scenario, full table: sweep all four known combinations, each held for one cycle; out matches REQ-011 immediately, and out_q matches it one edge later.
REQ-033 Scenario, unknown operand: a=0, b=x -> out=x; at the next edge out_q is unchanged and x_flag=1; then a=b=0 -> x_flag stays 1.
REQ-034 Scenario, transition counting: toggle b 0/1 five times with a=1, changing once per cycle -> rise_cnt=5. Then hold a=b=1 for ten cycles -> rise_cnt stays 5.
REQ-035 Scenario, saturation: with CNT_W=2, apply four 0->1 transitions -> rise_cnt=3 and it stays 3.
REQ-036 Scenario, reset priority: drive rst=1 in the same cycle as a 0->1 transition with x_flag=1 -> next state out_q=0, out_vld=0, x_flag=0, rise_cnt=0, while out still reflects a and b.

Source files
------------

// File: rtl/my_and.sv
// Two-input AND with registered copy, sticky unknown-operand flag and a
// saturating count of registered 0->1 transitions.
module my_and #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    output logic             out,
    output logic             out_q,
    output logic             out_vld,
    output logic             x_flag,
    output logic [CNT_W-1:0] rise_cnt
);

    logic known;
    logic res;
    logic rise;

    // Operands count as known only when each is a strict 0 or 1; x/z on either
    // side poisons the result even if the other operand is 0.
    always_comb begin
        known = ((a === 1'b0) || (a === 1'b1)) && ((b === 1'b0) || (b === 1'b1));
        res   = a & b;
        rise  = known && res && !out_q;
    end

    always_comb begin
        out = 1'bx;
        if (known) begin
            out = res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q    <= 1'b0;
            out_vld  <= 1'b0;
            x_flag   <= 1'b0;
            rise_cnt <= '0;
        end else if (known) begin
            out_q   <= res;
            out_vld <= 1'b1;
            if (rise && (rise_cnt != {CNT_W{1'b1}})) begin
                rise_cnt <= rise_cnt + 1'b1;
            end
        end else begin
            x_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_my_and.sv
// Directed-vector bench for my_and; a second instance with CNT_W=2 covers
// counter saturation on the same stimulus.
module tb_my_and;

    logic        clk;
    logic        rst;
    logic        a;
    logic        b;
    logic        out;
    logic        out_q;
    logic        out_vld;
    logic        x_flag;
    logic [15:0] rise_cnt;
    logic        out2;
    logic        out_q2;
    logic        out_vld2;
    logic        x_flag2;
    logic [1:0]  rise_cnt2;

    int vecs = 0;
    int errs = 0;
    int exp_cnt;
    int exp_cnt2;
    logic four_state;
    logic probe;

    my_and #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .out(out), .out_q(out_q),
        .out_vld(out_vld), .x_flag(x_flag), .rise_cnt(rise_cnt)
    );

    my_and #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .a(a), .b(b), .out(out2), .out_q(out_q2),
        .out_vld(out_vld2), .x_flag(x_flag2), .rise_cnt(rise_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag, input logic q, input logic vld,
                              input logic xf, input int cnt, input int cnt2);
        chk({tag, " out_q"}, 32'(out_q), 32'(q));
        chk({tag, " out_vld"}, 32'(out_vld), 32'(vld));
        chk({tag, " x_flag"}, 32'(x_flag), 32'(xf));
        chk({tag, " rise_cnt"}, 32'(rise_cnt), 32'(cnt));
        chk({tag, " rise_cnt_sat"}, 32'(rise_cnt2), 32'(cnt2));
    endtask

    initial begin
        logic [1:0] row;
        logic       q_exp;
        probe      = 1'bx;
        four_state = (probe === 1'bx);

        rst = 1'b1; a = 1'b0; b = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_regs("reset", 1'b0, 1'b0, 1'b0, 0, 0);

        // Basic truth table walk, combinational out then one-edge latency
        a = 1'b0; b = 1'b0; #1; chk("tt out 00", 32'(out), 32'd0);
        a = 1'b1;           #1; chk("tt out 10", 32'(out), 32'd0);
        b = 1'b1;           #1; chk("tt out 11", 32'(out), 32'd1);
        tick();
        exp_cnt = 1; exp_cnt2 = 1;
        check_regs("tt edge", 1'b1, 1'b1, 1'b0, exp_cnt, exp_cnt2);

        // Full table sweep; the 11 row after 10 is a fresh rise
        for (int i = 0; i < 4; i++) begin
            row = 2'(i);
            a = row[1]; b = row[0];
            q_exp = row[1] & row[0];
            #1;
            chk($sformatf("sweep out row%0d", i), 32'(out), 32'(q_exp));
            tick();
            chk($sformatf("sweep out_q row%0d", i), 32'(out_q), 32'(q_exp));
        end
        exp_cnt = 2; exp_cnt2 = 2;
        check_regs("sweep end", 1'b1, 1'b1, 1'b0, exp_cnt, exp_cnt2);

        // Five 0->1 toggles of b with a=1; the 2-bit copy saturates at 3
        a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b = 1'b0; tick();
            b = 1'b1; tick();
        end
        exp_cnt = 7; exp_cnt2 = 3;
        check_regs("toggle", 1'b1, 1'b1, 1'b0, exp_cnt, exp_cnt2);

        for (int i = 0; i < 10; i++) tick();
        check_regs("hold11", 1'b1, 1'b1, 1'b0, exp_cnt, exp_cnt2);

        // Mid-cycle operand glitch only moves the combinational output
        b = 1'b0; #1;
        chk("glitch out", 32'(out), 32'd0);
        chk("glitch out_q", 32'(out_q), 32'd1);
        b = 1'b1; #1;
        tick();
        check_regs("post glitch", 1'b1, 1'b1, 1'b0, exp_cnt, exp_cnt2);

        a = 1'b0; b = 1'b0; tick();
        check_regs("clear", 1'b0, 1'b1, 1'b0, exp_cnt, exp_cnt2);

        // Unknown operands are only observable on a four-state simulator
        if (four_state) begin
            a = 1'b0; b = 1'bx; #1;
            chk("x out", 32'(out), {31'd0, 1'bx});
            a = 1'b1; b = 1'b1; tick();
            a = 1'b0; b = 1'bx; tick();
            chk("x hold out_q", 32'(out_q), 32'd1);
            chk("x flag set", 32'(x_flag), 32'd1);
            a = 1'b0; b = 1'b0; tick();
            chk("x flag sticky", 32'(x_flag), 32'd1);
            chk("x out_q after 00", 32'(out_q), 32'd0);
            exp_cnt = 8;
        end

        // Reset wins over a pending rise and any set flag
        a = 1'b1; b = 1'b1; rst = 1'b1; #1;
        chk("rst out comb", 32'(out), 32'd1);
        tick();
        check_regs("rst prio", 1'b0, 1'b0, 1'b0, 0, 0);
        chk("rst out during", 32'(out), 32'd1);
        rst = 1'b0;
        tick();
        check_regs("post rst", 1'b1, 1'b1, 1'b0, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
